// File: rtl/coproc_pkg.sv
// Shared definitions for the coprocessor writeback path: frame defaults,
// pixel packing ratio and the writeback FSM state type.
package coproc_pkg;

  parameter int unsigned ImgWDefault = 256;
  parameter int unsigned ImgHDefault = 256;
  parameter int unsigned PxPerWord   = 4;
  parameter int unsigned LaneW       = $clog2(PxPerWord);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } wb_state_e;

endpackage

// File: rtl/px_pack4.sv
// Packs four 8-bit pixels into one 32-bit word; word presents the merged value
// including the pixel accepted this cycle so the caller can register it directly.
module px_pack4
  import coproc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             valid,
  input  logic [LaneW-1:0] lane,
  input  logic [7:0]       data,
  output logic [31:0]      word,
  output logic             word_ready
);

  logic [31:0] word_q, word_d;

  always_comb begin
    word_d = word_q;
    if (clr) begin
      word_d = '0;
    end else if (valid) begin
      unique case (lane)
        2'd0:    word_d[7:0]   = data;
        2'd1:    word_d[15:8]  = data;
        2'd2:    word_d[23:16] = data;
        default: word_d[31:24] = data;
      endcase
    end
  end

  assign word       = word_d;
  assign word_ready = valid && !clr && (&lane);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/addr_calc_wb_dma.sv
// Frame writeback: tracks raster position of incoming pixels, packs them four
// per word and issues sequential result-memory writes.
module addr_calc_wb_dma
  import coproc_pkg::*;
#(
  parameter int unsigned IMG_W = ImgWDefault,
  parameter int unsigned IMG_H = ImgHDefault
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        px_valid,
  input  logic [7:0]  px_data,
  output logic        mem_we,
  output logic [13:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [7:0]  col_cnt,
  output logic [7:0]  row_cnt,
  output logic        busy,
  output logic        done
);

  localparam logic [7:0] ColMax = 8'(IMG_W - 1);
  localparam logic [7:0] RowMax = 8'(IMG_H - 1);

  wb_state_e   state_q, state_d;
  logic [7:0]  col_q, col_d;
  logic [7:0]  row_q, row_d;
  logic [13:0] waddr_q, waddr_d;
  logic        mem_we_q, mem_we_d;
  logic [13:0] mem_waddr_q, mem_waddr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        done_q, done_d;

  logic        pack_clr;
  logic        accept;
  logic [31:0] pack_word;
  logic        pack_ready;

  // abort dominates px_valid, so a pixel arriving with abort is never packed
  assign accept = (state_q == StRun) && px_valid && !abort;

  px_pack4 u_px_pack4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (pack_clr),
    .valid      (accept),
    .lane       (col_q[LaneW-1:0]),
    .data       (px_data),
    .word       (pack_word),
    .word_ready (pack_ready)
  );

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    waddr_d     = waddr_q;
    mem_we_d    = 1'b0;
    mem_waddr_d = mem_waddr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;
    pack_clr    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StRun;
          col_d    = '0;
          row_d    = '0;
          waddr_d  = '0;
          pack_clr = 1'b1;
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
        end else if (px_valid) begin
          if (col_q == ColMax) begin
            col_d = '0;
            row_d = row_q + 8'd1;
            if (row_q == RowMax) begin
              state_d = StDone;
            end
          end else begin
            col_d = col_q + 8'd1;
          end
          if (pack_ready) begin
            mem_we_d    = 1'b1;
            mem_waddr_d = waddr_q;
            mem_wdata_d = pack_word;
            waddr_d     = waddr_q + 14'd1;
          end
        end
      end
      StDone: begin
        // first cycle carries the final write, second cycle carries done
        if (abort) begin
          state_d = StIdle;
        end else begin
          done_d = !done_q;
          if (done_q) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      col_q       <= '0;
      row_q       <= '0;
      waddr_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      waddr_q     <= waddr_d;
      mem_we_q    <= mem_we_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_waddr = mem_waddr_q;
  assign mem_wdata = mem_wdata_q;
  assign col_cnt   = col_q;
  assign row_cnt   = row_q;
  assign busy      = (state_q == StRun);
  assign done      = done_q;

endmodule

// File: doc/addr_calc_wb_dma.md
ADDR_CALC_WB_DMA -- requirements
Module: addr_calc_wb_dma

Interface
REQ-001 SHALL have parameter IMG_W, default 256, image width in pixels (power of two, multiple of 4).
REQ-002 SHALL have parameter IMG_H, default 256, image height in pixels.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-005 SHALL have port start  input  1  single-cycle request to begin writeback of one frame.
REQ-006 SHALL have port abort  input  1  cancel the frame in progress.
REQ-007 SHALL have port px_valid  input  1  processed pixel present on px_data this cycle.
REQ-008 SHALL have port px_data  input  8  processed pixel value, raster order.
REQ-009 SHALL have port mem_we  output  1  result-memory write strobe, one cycle per word.
REQ-010 SHALL have port mem_waddr  output  14  result-memory word address.
REQ-011 SHALL have port mem_wdata  output  32  four packed pixels.
REQ-012 SHALL have port col_cnt  output  8  column of the next pixel to be accepted.
REQ-013 SHALL have port row_cnt  output  8  row of the next pixel to be accepted.
REQ-014 SHALL have port busy  output  1  high in RUN.
REQ-015 SHALL have port done  output  1  one-cycle pulse when the frame is fully written.

Function
REQ-016 SHALL implement states IDLE, RUN, DONE.
REQ-017 IDLE -> RUN on start; counters, pack lane and word address cleared the same edge.
REQ-018 start SHALL be ignored while in RUN or DONE.
REQ-019 px_valid SHALL be ignored in IDLE and DONE (no counter change, no write).
REQ-020 In RUN, each px_valid cycle SHALL accept px_data into lane col_cnt[1:0] (lane 0 = bits [7:0], lane 3 = bits [31:24]) and advance col_cnt.
REQ-021 col_cnt SHALL wrap IMG_W-1 -> 0 and increment row_cnt on the same edge.
REQ-022 On acceptance of lane 3, mem_we SHALL be high the following cycle with the four packed pixels and current word address; word address then increments by 1.
REQ-023 mem_we SHALL be low in every other cycle; mem_waddr/mem_wdata hold their last values while mem_we is low.
REQ-024 Gaps in px_valid SHALL not alter packing or addressing (partial words held indefinitely).
REQ-025 Acceptance of pixel (row IMG_H-1, col IMG_W-1) SHALL move RUN -> DONE; final word write occurs the next cycle.
REQ-026 done SHALL assert for exactly one cycle, the cycle after the final mem_we; state then returns to IDLE.
REQ-027 abort in RUN or DONE SHALL return to IDLE on the next edge with no further mem_we and no done; a partial word is discarded; abort dominates start and px_valid.
REQ-028 A start in the cycle done is high SHALL be ignored; start in the following cycle is accepted.
REQ-029 Word address SHALL equal (row*IMG_W + col)/4, total IMG_W*IMG_H/4 words, last word 16383 at default size.

Reset
REQ-030 rst_n low at a clock edge SHALL force IDLE, mem_we=0, mem_waddr=0, mem_wdata=0, col_cnt=0, row_cnt=0, busy=0, done=0.
REQ-031 Reset mid-frame SHALL abandon the frame with no write and no done pulse.

Structure
REQ-032 IMG_W/IMG_H defaults, PX_PER_WORD=4, and the state enum SHALL reside in shared package coproc_pkg.
REQ-033 Pixel packing SHALL be a sub-module px_pack4 (lane select, 32-bit shift/hold register, word-ready flag); counters and FSM stay in the top.

Verification
REQ-034 Reset, start, 65536 back-to-back px_valid with px_data=col[7:0] -> 16384 mem_we, word 0 wdata=0x03020100, last mem_waddr=16383, done one cycle after last mem_we.
REQ-035 Random px_valid gaps (50% duty) over a full frame -> identical write sequence to REQ-034, busy high throughout.
REQ-036 px_valid pulses in IDLE then start -> no writes before start; first word uses only post-start pixels.
REQ-037 abort after 6 pixels (one word written, two pending) -> exactly one mem_we at address 0, no done, next start writes from address 0.
REQ-038 start asserted mid-frame and in the done cycle -> ignored; counters unaffected.
REQ-039 rst_n low for one cycle at pixel 1000 -> all outputs zero next cycle, no done, subsequent frame correct.
